// File: rtl/execute_stage_pkg.sv
// Shared widths, encodings and the M pipeline register layout for the Y86-64 execute stage.
// Optional ALU extension (OR/SHL) is controlled by the EXEC_EXT_ALU_EN macro.
package execute_stage_pkg;

    localparam int unsigned NIBBLE = 4;
    localparam int unsigned D_WORD = 64;

    typedef enum logic [NIBBLE-1:0] {
        IHALT   = 4'h0,
        INOP    = 4'h1,
        IRRMOVQ = 4'h2,
        IIRMOVQ = 4'h3,
        IRMMOVQ = 4'h4,
        IMRMOVQ = 4'h5,
        IOPQ    = 4'h6,
        IJXX    = 4'h7,
        ICALL   = 4'h8,
        IRET    = 4'h9,
        IPUSHQ  = 4'hA,
        IPOPQ   = 4'hB
    } icode_t;

    typedef enum logic [NIBBLE-1:0] {
        ALUADD = 4'h0,
        ALUSUB = 4'h1,
        ALUAND = 4'h2,
        ALUXOR = 4'h3,
        ALUOR  = 4'h4,
        ALUSHL = 4'h5
    } alufun_t;

    typedef enum logic [NIBBLE-1:0] {
        SAOK = 4'h1,
        SADR = 4'h2,
        SINS = 4'h3,
        SHLT = 4'h4
    } stat_t;

    typedef enum logic [NIBBLE-1:0] {
        C_YES = 4'h0,
        C_LE  = 4'h1,
        C_L   = 4'h2,
        C_E   = 4'h3,
        C_NE  = 4'h4,
        C_GE  = 4'h5,
        C_G   = 4'h6
    } cond_t;

    localparam logic [NIBBLE-1:0] RNONE = 4'hF;

    typedef struct packed {
        logic [NIBBLE-1:0] stat;
        logic [NIBBLE-1:0] icode;
        logic              cnd;
        logic [D_WORD-1:0] val_e;
        logic [D_WORD-1:0] val_a;
        logic [NIBBLE-1:0] dst_e;
        logic [NIBBLE-1:0] dst_m;
    } mreg_t;

    localparam mreg_t M_BUBBLE = '{
        stat:  SAOK,
        icode: INOP,
        cnd:   1'b0,
        val_e: '0,
        val_a: '0,
        dst_e: RNONE,
        dst_m: RNONE
    };

    // Any exception status in a later stage freezes the condition codes.
    function automatic logic stat_is_exc(input logic [NIBBLE-1:0] s);
        return (s == SADR) || (s == SINS) || (s == SHLT);
    endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Signal bundle between the E register, the execute stage and the M register consumers.
interface execute_stage_if;
    import execute_stage_pkg::*;

    logic [NIBBLE-1:0] E_stat_i;
    logic [NIBBLE-1:0] E_icode_i;
    logic [NIBBLE-1:0] E_ifun_i;
    logic [D_WORD-1:0] E_valC_i;
    logic [D_WORD-1:0] E_valA_i;
    logic [D_WORD-1:0] E_valB_i;
    logic [NIBBLE-1:0] E_dstE_i;
    logic [NIBBLE-1:0] E_dstM_i;
    logic [NIBBLE-1:0] m_stat_i;
    logic [NIBBLE-1:0] W_stat_i;
    logic              M_bubble_i;

    logic [D_WORD-1:0] e_valE_o;
    logic [NIBBLE-1:0] e_dstE_o;
    logic              e_Cnd_o;
    logic [2:0]        cc_o;
    logic [NIBBLE-1:0] M_stat_o;
    logic [NIBBLE-1:0] M_icode_o;
    logic              M_Cnd_o;
    logic [D_WORD-1:0] M_valE_o;
    logic [D_WORD-1:0] M_valA_o;
    logic [NIBBLE-1:0] M_dstE_o;
    logic [NIBBLE-1:0] M_dstM_o;

    modport slave (
        input  E_stat_i, E_icode_i, E_ifun_i, E_valC_i, E_valA_i, E_valB_i,
               E_dstE_i, E_dstM_i, m_stat_i, W_stat_i, M_bubble_i,
        output e_valE_o, e_dstE_o, e_Cnd_o, cc_o,
               M_stat_o, M_icode_o, M_Cnd_o, M_valE_o, M_valA_o, M_dstE_o, M_dstM_o
    );

    modport master (
        output E_stat_i, E_icode_i, E_ifun_i, E_valC_i, E_valA_i, E_valB_i,
               E_dstE_i, E_dstM_i, m_stat_i, W_stat_i, M_bubble_i,
        input  e_valE_o, e_dstE_o, e_Cnd_o, cc_o,
               M_stat_o, M_icode_o, M_Cnd_o, M_valE_o, M_valA_o, M_dstE_o, M_dstM_o
    );

endinterface

// File: rtl/execute_stage_alu.sv
// Combinational Y86-64 ALU producing valE and the {ZF,SF,OF} flags.
// EXEC_EXT_ALU_EN adds OR and SHL; otherwise unknown functions yield 0 and op_ok_o=0.
module execute_stage_alu
    import execute_stage_pkg::*;
(
    input  logic [D_WORD-1:0] alu_a_i,
    input  logic [D_WORD-1:0] alu_b_i,
    input  logic [NIBBLE-1:0] alufun_i,
    output logic [D_WORD-1:0] val_e_o,
    output logic [2:0]        flags_o,
    output logic              op_ok_o
);

    logic of;

    always_comb begin
        val_e_o = '0;
        of      = 1'b0;
        op_ok_o = 1'b1;
        case (alufun_t'(alufun_i))
            ALUADD: begin
                val_e_o = alu_b_i + alu_a_i;
                of      = (alu_a_i[D_WORD-1] == alu_b_i[D_WORD-1]) &&
                          (val_e_o[D_WORD-1] != alu_a_i[D_WORD-1]);
            end
            ALUSUB: begin
                val_e_o = alu_b_i - alu_a_i;
                of      = (alu_a_i[D_WORD-1] != alu_b_i[D_WORD-1]) &&
                          (val_e_o[D_WORD-1] != alu_b_i[D_WORD-1]);
            end
            ALUAND: val_e_o = alu_b_i & alu_a_i;
            ALUXOR: val_e_o = alu_b_i ^ alu_a_i;
`ifdef EXEC_EXT_ALU_EN
            ALUOR:  val_e_o = alu_b_i | alu_a_i;
            ALUSHL: val_e_o = alu_b_i << alu_a_i[5:0];
`endif
            default: op_ok_o = 1'b0;
        endcase
    end

    assign flags_o = {(val_e_o == '0), val_e_o[D_WORD-1], of};

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: operand select, ALU, condition codes, jump/cmov condition and M register.
// Honours EXEC_EXT_ALU_EN through the ALU sub-module.
module execute_stage
    import execute_stage_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    execute_stage_if.slave  bus
);

    icode_t            icode;
    logic [D_WORD-1:0] alu_a;
    logic [D_WORD-1:0] alu_b;
    logic [NIBBLE-1:0] alufun;
    logic [D_WORD-1:0] val_e;
    logic [2:0]        alu_flags;
    logic              op_ok;
    logic              set_cc;
    logic [2:0]        cc_d, cc_q;
    logic              zf, sf, of;
    logic              cnd;
    logic [NIBBLE-1:0] dst_e;
    mreg_t             m_d, m_q;

    assign icode = icode_t'(bus.E_icode_i);

    always_comb begin
        alu_a = '0;
        case (icode)
            IRRMOVQ, IOPQ:             alu_a = bus.E_valA_i;
            IIRMOVQ, IRMMOVQ, IMRMOVQ: alu_a = bus.E_valC_i;
            ICALL, IPUSHQ:             alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
            IRET, IPOPQ:               alu_a = 64'd8;
            default:                   alu_a = '0;
        endcase
    end

    always_comb begin
        alu_b = '0;
        case (icode)
            IRMMOVQ, IMRMOVQ, IOPQ, ICALL, IPUSHQ, IRET, IPOPQ: alu_b = bus.E_valB_i;
            default:                                             alu_b = '0;
        endcase
    end

    assign alufun = (icode == IOPQ) ? bus.E_ifun_i : ALUADD;

    execute_stage_alu u_alu (
        .alu_a_i  (alu_a),
        .alu_b_i  (alu_b),
        .alufun_i (alufun),
        .val_e_o  (val_e),
        .flags_o  (alu_flags),
        .op_ok_o  (op_ok)
    );

    // Unsupported OPq functions leave CC untouched as if the op never ran.
    assign set_cc = (icode == IOPQ) && op_ok &&
                    !stat_is_exc(bus.m_stat_i) && !stat_is_exc(bus.W_stat_i);

    assign cc_d = set_cc ? alu_flags : cc_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cc_q <= 3'b100;
        end else begin
            cc_q <= cc_d;
        end
    end

    assign {zf, sf, of} = cc_q;

    always_comb begin
        cnd = 1'b0;
        case (cond_t'(bus.E_ifun_i))
            C_YES:   cnd = 1'b1;
            C_LE:    cnd = (sf ^ of) | zf;
            C_L:     cnd = sf ^ of;
            C_E:     cnd = zf;
            C_NE:    cnd = !zf;
            C_GE:    cnd = !(sf ^ of);
            C_G:     cnd = !(sf ^ of) && !zf;
            default: cnd = 1'b0;
        endcase
    end

    assign dst_e = ((icode == IRRMOVQ) && !cnd) ? RNONE : bus.E_dstE_i;

    always_comb begin
        m_d = M_BUBBLE;
        if (!bus.M_bubble_i) begin
            m_d.stat  = bus.E_stat_i;
            m_d.icode = bus.E_icode_i;
            m_d.cnd   = cnd;
            m_d.val_e = val_e;
            m_d.val_a = bus.E_valA_i;
            m_d.dst_e = dst_e;
            m_d.dst_m = bus.E_dstM_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m_q <= M_BUBBLE;
        end else begin
            m_q <= m_d;
        end
    end

    assign bus.e_valE_o  = val_e;
    assign bus.e_dstE_o  = dst_e;
    assign bus.e_Cnd_o   = cnd;
    assign bus.cc_o      = cc_q;
    assign bus.M_stat_o  = m_q.stat;
    assign bus.M_icode_o = m_q.icode;
    assign bus.M_Cnd_o   = m_q.cnd;
    assign bus.M_valE_o  = m_q.val_e;
    assign bus.M_valA_o  = m_q.val_a;
    assign bus.M_dstE_o  = m_q.dst_e;
    assign bus.M_dstM_o  = m_q.dst_m;

endmodule

// File: tb/tb_execute_stage.sv
// Directed plus randomized bench for execute_stage against a behavioural reference model.
// Model follows EXEC_EXT_ALU_EN the same way the design does.
module tb_execute_stage;
    import execute_stage_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    execute_stage_if bus ();

    execute_stage dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference state: condition codes and the expected M register contents.
    logic        mdl_valid = 1'b0;
    logic [2:0]  mdl_cc;
    logic [3:0]  mdl_ms, mdl_mi, mdl_mde, mdl_mdm;
    logic        mdl_mc;
    logic [63:0] mdl_mve, mdl_mva;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic exc(input logic [3:0] s);
        return (s == 4'd2) || (s == 4'd3) || (s == 4'd4);
    endfunction

    task automatic step(input logic r, input logic [3:0] stat, input logic [3:0] icode,
                        input logic [3:0] ifun, input logic [63:0] valc,
                        input logic [63:0] vala, input logic [63:0] valb,
                        input logic [3:0] dste, input logic [3:0] dstm,
                        input logic [3:0] mstat, input logic [3:0] wstat, input logic bub);
        logic [63:0] a, b, v;
        logic [64:0] w;
        logic [3:0]  op, de;
        logic        ok, ovf, c, zf, sf, of;
        @(negedge clk);
        rst = r;
        bus.E_stat_i = stat;  bus.E_icode_i = icode; bus.E_ifun_i = ifun;
        bus.E_valC_i = valc;  bus.E_valA_i = vala;   bus.E_valB_i = valb;
        bus.E_dstE_i = dste;  bus.E_dstM_i = dstm;
        bus.m_stat_i = mstat; bus.W_stat_i = wstat;  bus.M_bubble_i = bub;
        #1;
        case (icode)
            IRRMOVQ, IOPQ:             a = vala;
            IIRMOVQ, IRMMOVQ, IMRMOVQ: a = valc;
            ICALL, IPUSHQ:             a = -64'd8;
            IRET, IPOPQ:               a = 64'd8;
            default:                   a = 64'd0;
        endcase
        case (icode)
            IRMMOVQ, IMRMOVQ, IOPQ, ICALL, IPUSHQ, IRET, IPOPQ: b = valb;
            default:                                             b = 64'd0;
        endcase
        op  = (icode == IOPQ) ? ifun : 4'd0;
        ok  = 1'b1;
        ovf = 1'b0;
        v   = 64'd0;
        // Overflow judged on the sign-extended 65-bit exact result.
        case (op)
            4'd0: begin w = {a[63], a} + {b[63], b}; v = w[63:0]; ovf = w[64] ^ w[63]; end
            4'd1: begin w = {b[63], b} - {a[63], a}; v = w[63:0]; ovf = w[64] ^ w[63]; end
            4'd2: v = a & b;
            4'd3: v = a ^ b;
`ifdef EXEC_EXT_ALU_EN
            4'd4: v = a | b;
            4'd5: v = b << a[5:0];
`endif
            default: ok = 1'b0;
        endcase
        {zf, sf, of} = mdl_cc;
        case (ifun)
            4'd0: c = 1'b1;
            4'd1: c = (sf != of) || zf;
            4'd2: c = (sf != of);
            4'd3: c = zf;
            4'd4: c = !zf;
            4'd5: c = (sf == of);
            4'd6: c = (sf == of) && !zf;
            default: c = 1'b0;
        endcase
        de = (icode == IRRMOVQ && !c) ? 4'hF : dste;
        if (mdl_valid) begin
            check("cc",      64'(bus.cc_o),      64'(mdl_cc));
            check("M_stat",  64'(bus.M_stat_o),  64'(mdl_ms));
            check("M_icode", 64'(bus.M_icode_o), 64'(mdl_mi));
            check("M_Cnd",   64'(bus.M_Cnd_o),   64'(mdl_mc));
            check("M_valE",  bus.M_valE_o,       mdl_mve);
            check("M_valA",  bus.M_valA_o,       mdl_mva);
            check("M_dstE",  64'(bus.M_dstE_o),  64'(mdl_mde));
            check("M_dstM",  64'(bus.M_dstM_o),  64'(mdl_mdm));
            check("e_valE",  bus.e_valE_o,       v);
            check("e_dstE",  64'(bus.e_dstE_o),  64'(de));
            check("e_Cnd",   64'(bus.e_Cnd_o),   64'(c));
        end
        if (r) begin
            mdl_valid = 1'b1;
            mdl_cc = 3'b100;
            mdl_ms = 4'd1; mdl_mi = 4'd1; mdl_mc = 1'b0;
            mdl_mve = 64'd0; mdl_mva = 64'd0; mdl_mde = 4'hF; mdl_mdm = 4'hF;
        end else begin
            if (icode == IOPQ && ok && !exc(mstat) && !exc(wstat))
                mdl_cc = {v == 64'd0, v[63], ovf};
            if (bub) begin
                mdl_ms = 4'd1; mdl_mi = 4'd1; mdl_mc = 1'b0;
                mdl_mve = 64'd0; mdl_mva = 64'd0; mdl_mde = 4'hF; mdl_mdm = 4'hF;
            end else begin
                mdl_ms = stat; mdl_mi = icode; mdl_mc = c;
                mdl_mve = v; mdl_mva = vala; mdl_mde = de; mdl_mdm = dstm;
            end
        end
    endtask

    task automatic nop();
        step(1'b0, 4'd1, 4'd1, 4'd0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 4'd1, 4'd1, 1'b0);
    endtask

    function automatic logic [63:0] rnd_word();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return 64'd5;
            2: return 64'h7FFF_FFFF_FFFF_FFFF;
            3: return 64'h8000_0000_0000_0000;
            4: return 64'hFFFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    function automatic logic [3:0] rnd_stat();
        if ($urandom_range(0, 3) != 0) return 4'd1;
        return 4'($urandom_range(0, 15));
    endfunction

    initial begin
        bus.E_stat_i = 4'd1; bus.E_icode_i = 4'd1; bus.E_ifun_i = 4'd0;
        bus.E_valC_i = '0;   bus.E_valA_i = '0;    bus.E_valB_i = '0;
        bus.E_dstE_i = 4'hF; bus.E_dstM_i = 4'hF;
        bus.m_stat_i = 4'd1; bus.W_stat_i = 4'd1;  bus.M_bubble_i = 1'b0;

        step(1'b1, 4'd1, IOPQ, 4'd0, 64'd0, 64'd1, 64'd2, 4'd3, 4'd4, 4'd1, 4'd1, 1'b0);
        step(1'b1, 4'd1, IOPQ, 4'd0, 64'd0, 64'd1, 64'd2, 4'd3, 4'd4, 4'd1, 4'd1, 1'b0);
        check("rst_cc",      64'(bus.cc_o),      64'b100);
        check("rst_M_icode", 64'(bus.M_icode_o), 64'h1);
        check("rst_M_dstE",  64'(bus.M_dstE_o),  64'hF);
        check("rst_M_dstM",  64'(bus.M_dstM_o),  64'hF);

        step(1'b0, 4'd1, IOPQ, 4'd1, 64'd0, 64'd5, 64'd5, 4'd2, 4'hF, 4'd1, 4'd1, 1'b0);
        check("sub_valE", bus.e_valE_o, 64'd0);
        step(1'b0, 4'd1, IJXX, 4'd3, 64'h40, 64'd0, 64'd0, 4'hF, 4'hF, 4'd1, 4'd1, 1'b0);
        check("sub_cc", 64'(bus.cc_o), 64'b100);
        check("je_cnd", 64'(bus.e_Cnd_o), 64'd1);

        step(1'b0, 4'd1, IOPQ, 4'd0, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF,
             64'h7FFF_FFFF_FFFF_FFFF, 4'd2, 4'hF, 4'd1, 4'd1, 1'b0);
        check("add_valE", bus.e_valE_o, 64'hFFFF_FFFF_FFFF_FFFE);
        step(1'b0, 4'd1, IJXX, 4'd2, 64'h40, 64'd0, 64'd0, 4'hF, 4'hF, 4'd1, 4'd1, 1'b0);
        check("add_cc", 64'(bus.cc_o), 64'b011);
        check("jl_cnd", 64'(bus.e_Cnd_o), 64'd0);

        step(1'b0, 4'd1, IOPQ, 4'd1, 64'd0, 64'd5, 64'd5, 4'd2, 4'hF, 4'd1, 4'd1, 1'b0);
        step(1'b0, 4'd1, IRRMOVQ, 4'd4, 64'd0, 64'h1234, 64'd0, 4'd3, 4'hF, 4'd1, 4'd1, 1'b0);
        check("cmov_dstE", 64'(bus.e_dstE_o), 64'hF);
        check("cmov_valE", bus.e_valE_o, 64'h1234);
        nop();
        check("cmov_M_dstE", 64'(bus.M_dstE_o), 64'hF);

        step(1'b0, 4'd1, IOPQ, 4'd3, 64'd0, 64'd1, 64'd0, 4'd2, 4'hF, 4'd2, 4'd1, 1'b0);
        nop();
        check("sadr_cc",   64'(bus.cc_o), 64'b100);
        check("sadr_valE", bus.M_valE_o,  64'd1);
        step(1'b0, 4'd1, IOPQ, 4'd3, 64'd0, 64'd1, 64'd0, 4'd2, 4'hF, 4'd1, 4'd4, 1'b0);
        nop();
        check("shlt_cc", 64'(bus.cc_o), 64'b100);

        step(1'b0, 4'd1, ICALL, 4'd0, 64'h200, 64'd0, 64'h100, 4'd4, 4'hF, 4'd1, 4'd1, 1'b1);
        check("call_valE", bus.e_valE_o, 64'hF8);
        nop();
        check("bub_M_icode", 64'(bus.M_icode_o), 64'h1);
        check("bub_M_valE",  bus.M_valE_o,       64'd0);

        for (int i = 0; i < 400; i++) begin
            logic [3:0] ic;
            ic = ($urandom_range(0, 2) == 0) ? IOPQ : 4'($urandom_range(0, 15));
            step(($urandom_range(0, 49) == 0), 4'($urandom_range(0, 15)), ic,
                 4'($urandom_range(0, 15)), rnd_word(), rnd_word(), rnd_word(),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 rnd_stat(), rnd_stat(), ($urandom_range(0, 5) == 0));
        end
        nop();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Consumer side of the E pipeline register in the Y86-64 pipe.
- Takes E_* register outputs and performs the ALU operation.
- Maintains the condition-code register (ZF/SF/OF) and evaluates jump/cmov conditions.
- Produces e_* forwarding signals and owns the M pipeline register that feeds the memory stage.

Parameters:
- None. Widths come from `D_WORD (64) and `NIBBLE (4) in define.v.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- E_stat_i, E_icode_i, E_ifun_i  in  4 each  from the E register.
- E_valC_i, E_valA_i, E_valB_i  in  64 each  from the E register.
- E_dstE_i, E_dstM_i  in  4 each  from the E register.
- m_stat_i  in  4  memory-stage status, combinational.
- W_stat_i  in  4  write-back status.
- M_bubble_i  in  1  load bubble into the M register.
- e_valE_o  out  64  ALU result, combinational, for forwarding.
- e_dstE_o  out  4  destination after cmov squash.
- e_Cnd_o  out  1  condition result, used for branch-mispredict detection.
- cc_o  out  3  {ZF,SF,OF}.
- M_stat_o, M_icode_o  out  4 each.
- M_Cnd_o  out  1.
- M_valE_o, M_valA_o  out  64 each.
- M_dstE_o, M_dstM_o  out  4 each.

Behaviour:
- Reset (rst_i=1 at posedge) has priority over everything:
  - CC = {ZF=1, SF=0, OF=0}.
  - M_stat=SAOK, M_icode=INOP, M_Cnd=0, M_valE=0, M_valA=0, M_dstE=M_dstM=RNONE.
- aluA:
  - E_valA for IRRMOVQ, IOPQ.
  - E_valC for IIRMOVQ, IRMMOVQ, IMRMOVQ.
  - -8 for ICALL, IPUSHQ.
  - +8 for IRET, IPOPQ.
  - 0 otherwise.
- aluB:
  - E_valB for IRMMOVQ, IMRMOVQ, IOPQ, ICALL, IPUSHQ, IRET, IPOPQ.
  - 0 otherwise.
- alufun = E_ifun when icode is IOPQ, else ALUADD.
- valE by alufun: ADD B+A, SUB B-A, AND B&A, XOR B^A. 64-bit wrap, no carry kept.
- Flags:
  - ZF = (valE==0); SF = valE[63].
  - OF for ADD: A[63]==B[63] && valE[63]!=A[63].
  - OF for SUB: A[63]!=B[63] && valE[63]!=B[63].
  - OF for AND/XOR: 0.
- set_cc = (E_icode==IOPQ) && m_stat_i and W_stat_i are both not in {SADR, SINS, SHLT}.
  - When set, CC is written at posedge and visible from the next cycle.
  - An instruction's own e_Cnd uses the pre-update CC.
- Conditions by ifun:
  - 0 always; 1 LE (SF^OF)|ZF; 2 L SF^OF; 3 E ZF; 4 NE !ZF.
  - 5 GE !(SF^OF); 6 G !(SF^OF)&!ZF; 7–15 give 0.
  - e_Cnd is evaluated for all icodes; consumers qualify it by icode.
- e_dstE = RNONE when icode==IRRMOVQ && !e_Cnd, else E_dstE_i.
- M register, 1-cycle latency:
  - M_bubble_i=1 loads SAOK/INOP/Cnd=0/vals 0/dst RNONE.
  - Otherwise loads {E_stat, E_icode, e_Cnd, e_valE, E_valA, e_dstE, E_dstM}.
- M_bubble_i does not block a CC update in the same cycle; only m_stat_i/W_stat_i gate CC.
- Reset asserted mid-stream: the next posedge clears CC and the M register regardless of M_bubble_i or set_cc.

Optional Feature:
- Macro EXEC_EXT_ALU_EN.
- Defined:
  - IOPQ ifun 4 = OR (B|A, OF=0).
  - ifun 5 = SHL (B << A[5:0], OF=0).
  - Both set CC normally.
- Undefined:
  - IOPQ ifun 4–15 gives valE=0 and suppresses set_cc, so CC is unchanged.

Decomposition:
- define.v owns all shared constants and widths:
  - `NIBBLE, `D_WORD.
  - icodes IHALT..IPOPQ (0–B).
  - ALUADD/SUB/AND/XOR (0–3), plus ALUOR/ALUSHL (4/5).
  - stat codes SAOK=1, SADR=2, SINS=3, SHLT=4.
  - RNONE=F.
  - condition ifun codes.
- One combinational sub-module, alu: inputs aluA, aluB, alufun; outputs valE, {ZF,SF,OF}.
- The CC register, condition logic and M register live in execute_stage.

Test Plan:
- Reset held 2 cycles → cc_o=3'b100, M_icode=INOP, M_dstE=M_dstM=F.
- IOPQ SUB, valA=5, valB=5 → e_valE=0.
  - Next cycle cc_o=100 (ZF=1).
  - Following JXX ifun 3 (E) gives e_Cnd=1.
- IOPQ ADD, valA=valB=0x7FFF_FFFF_FFFF_FFFF → e_valE=0xFFFF_FFFF_FFFF_FFFE.
  - Next cycle cc_o=011 (SF, OF).
  - JXX ifun 2 (L) gives e_Cnd=0.
- IRRMOVQ ifun 4 (cmovne) with ZF=1, E_dstE=3 → e_dstE=F and M_dstE=F next cycle; e_valE=valA.
- IOPQ XOR with m_stat_i=SADR → cc_o unchanged; M still loads valE.
  - Repeat with W_stat_i=SHLT → cc_o unchanged.
- ICALL with valB=0x100 and M_bubble_i=1 → e_valE=0xF8, but M_icode=INOP and M_valE=0 next cycle.
